// File: rtl/tlc_traffic_model.sv
// ---------------------------------------------------------------------------
// tlc_traffic_model
//   Behavioural environment model for a two-street traffic-light controller.
//   It keeps a car queue per street, drains that queue while the street's
//   light is green (one car every DEP_CYCLES green cycles), drives the
//   traffic sensors the controller consumes, and can optionally watch the
//   light outputs for illegal sequences.
//
//   Build option:
//     TLC_VIOLATION_CHECK_EN - when defined, the light-sequence monitor is
//                              built; when undefined, viol/viol_code are 0.
//
//   Ports:
//     clk        in   sole clock, everything updates on posedge
//     reset      in   synchronous active-high reset
//     arr_a/b    in   car-arrival pulse per street (one car per cycle)
//     La/Lb      in   light per street: 00 green, 01 yellow, 10 red, 11 bad
//     Ta/Tb      out  traffic sensor, high while the street queue is nonempty
//     qa/qb      out  queue count per street
//     dep_a/b    out  one-cycle pulse when a car leaves the street
//     ovf        out  sticky overflow flags, bit0 street A, bit1 street B
//     viol       out  sticky light-sequence violation flag
//     viol_code  out  first violation: 00 bad encoding, 01 both non-red,
//                     10 illegal transition
// ---------------------------------------------------------------------------
module tlc_traffic_model #(
  parameter int unsigned DEP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arr_a,
  input  logic       arr_b,
  input  logic [1:0] La,
  input  logic [1:0] Lb,
  output logic       Ta,
  output logic       Tb,
  output logic [3:0] qa,
  output logic [3:0] qb,
  output logic       dep_a,
  output logic       dep_b,
  output logic [1:0] ovf,
  output logic       viol,
  output logic [1:0] viol_code
);

  localparam logic [1:0] LIGHT_GREEN  = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_RED    = 2'b10;
  localparam logic [1:0] LIGHT_BAD    = 2'b11;

  localparam logic [3:0] Q_MAX    = 4'd15;
  localparam logic [3:0] DEP_LAST = 4'(DEP_CYCLES - 1);

  // Index 0 is street A, index 1 is street B.
  logic [1:0]      arr_s;
  logic [1:0][1:0] light_s;
  logic [1:0]      fire_s;

  logic [1:0][3:0] q_q;
  logic [1:0][3:0] q_d;
  logic [1:0][3:0] tmr_q;
  logic [1:0][3:0] tmr_d;
  logic [1:0]      dep_q;
  logic [1:0]      dep_d;
  logic [1:0]      ovf_q;
  logic [1:0]      ovf_d;

  assign arr_s   = {arr_b, arr_a};
  assign light_s = {Lb, La};

  // Queue, departure timer and overflow next-state for both streets.
  always_comb begin
    q_d    = q_q;
    tmr_d  = tmr_q;
    dep_d  = 2'b00;
    ovf_d  = ovf_q;
    fire_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      // A car leaves on the edge after the timer has seen DEP_CYCLES green
      // cycles with cars waiting.
      fire_s[i] = (light_s[i] == LIGHT_GREEN) && (q_q[i] != 4'd0) &&
                  (tmr_q[i] == DEP_LAST);
      if (fire_s[i]) begin
        tmr_d[i] = 4'd0;
        dep_d[i] = 1'b1;
        // An arrival in the same cycle replaces the departing car, so a
        // full queue can still accept it without overflowing.
        if (arr_s[i]) begin
          q_d[i] = q_q[i];
        end else begin
          q_d[i] = q_q[i] - 4'd1;
        end
      end else begin
        dep_d[i] = 1'b0;
        if ((light_s[i] != LIGHT_GREEN) || (q_q[i] == 4'd0)) begin
          tmr_d[i] = 4'd0;
        end else begin
          tmr_d[i] = tmr_q[i] + 4'd1;
        end
        if (arr_s[i]) begin
          if (q_q[i] == Q_MAX) begin
            q_d[i]   = q_q[i];
            ovf_d[i] = 1'b1;
          end else begin
            q_d[i]   = q_q[i] + 4'd1;
          end
        end else begin
          q_d[i] = q_q[i];
        end
      end
    end
  end

  // Queue/timer/departure/overflow state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q   <= '0;
      tmr_q <= '0;
      dep_q <= 2'b00;
      ovf_q <= 2'b00;
    end else begin
      q_q   <= q_d;
      tmr_q <= tmr_d;
      dep_q <= dep_d;
      ovf_q <= ovf_d;
    end
  end

  assign qa    = q_q[0];
  assign qb    = q_q[1];
  assign Ta    = (q_q[0] != 4'd0);
  assign Tb    = (q_q[1] != 4'd0);
  assign dep_a = dep_q[0];
  assign dep_b = dep_q[1];
  assign ovf   = ovf_q;

`ifdef TLC_VIOLATION_CHECK_EN

  // Legal per-street light changes: hold, red->green, green->yellow,
  // yellow->red.
  function automatic logic legal_step(input logic [1:0] prev_l,
                                      input logic [1:0] cur_l);
    logic ok;
    if (prev_l == cur_l) begin
      ok = 1'b1;
    end else begin
      case ({prev_l, cur_l})
        {LIGHT_RED,    LIGHT_GREEN}:  ok = 1'b1;
        {LIGHT_GREEN,  LIGHT_YELLOW}: ok = 1'b1;
        {LIGHT_YELLOW, LIGHT_RED}:    ok = 1'b1;
        default:                      ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  logic [1:0] prev_la_q;
  logic [1:0] prev_lb_q;
  logic       viol_q;
  logic       viol_d;
  logic [1:0] code_q;
  logic [1:0] code_d;
  logic       bad_enc_s;
  logic       both_go_s;
  logic       bad_step_s;

  // Violation detection; only the first offending cycle sets the code.
  always_comb begin
    bad_enc_s  = (La == LIGHT_BAD) || (Lb == LIGHT_BAD);
    both_go_s  = (La != LIGHT_RED) && (Lb != LIGHT_RED);
    bad_step_s = !legal_step(prev_la_q, La) || !legal_step(prev_lb_q, Lb);
    viol_d     = viol_q;
    code_d     = code_q;
    if (!viol_q && (bad_enc_s || both_go_s || bad_step_s)) begin
      viol_d = 1'b1;
      if (bad_enc_s) begin
        code_d = 2'b00;
      end else if (both_go_s) begin
        code_d = 2'b01;
      end else begin
        code_d = 2'b10;
      end
    end else begin
      viol_d = viol_q;
      code_d = code_q;
    end
  end

  // Previous-light history and sticky violation registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_la_q <= LIGHT_RED;
      prev_lb_q <= LIGHT_RED;
      viol_q    <= 1'b0;
      code_q    <= 2'b00;
    end else begin
      prev_la_q <= La;
      prev_lb_q <= Lb;
      viol_q    <= viol_d;
      code_q    <= code_d;
    end
  end

  assign viol      = viol_q;
  assign viol_code = code_q;

`else

  assign viol      = 1'b0;
  assign viol_code = 2'b00;

`endif

endmodule

// File: tb/tb_tlc_traffic_model.sv
// ---------------------------------------------------------------------------
// Directed bench for tlc_traffic_model (DEP_CYCLES = 2). Each stimulus cycle
// pushes the hand-computed outputs expected after that cycle's clock edge;
// a monitor on the falling edge pops and compares one entry per cycle.
// Violation expectations follow whether TLC_VIOLATION_CHECK_EN is defined.
// ---------------------------------------------------------------------------
module tb_tlc_traffic_model;

  localparam logic [1:0] G = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] R = 2'b10;
  localparam logic [1:0] X = 2'b11;

`ifdef TLC_VIOLATION_CHECK_EN
  localparam logic VCHK = 1'b1;
`else
  localparam logic VCHK = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] id;
    logic [3:0] qa;
    logic [3:0] qb;
    logic       ta;
    logic       tb;
    logic       da;
    logic       db;
    logic [1:0] ovf;
    logic       viol;
    logic [1:0] code;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       arr_a;
  logic       arr_b;
  logic [1:0] La;
  logic [1:0] Lb;
  logic       Ta;
  logic       Tb;
  logic [3:0] qa;
  logic [3:0] qb;
  logic       dep_a;
  logic       dep_b;
  logic [1:0] ovf;
  logic       viol;
  logic [1:0] viol_code;

  exp_t sb_q[$];
  int   total;
  int   bad;
  int   cyc_id;

  tlc_traffic_model #(.DEP_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .arr_a     (arr_a),
    .arr_b     (arr_b),
    .La        (La),
    .Lb        (Lb),
    .Ta        (Ta),
    .Tb        (Tb),
    .qa        (qa),
    .qb        (qb),
    .dep_a     (dep_a),
    .dep_b     (dep_b),
    .ovf       (ovf),
    .viol      (viol),
    .viol_code (viol_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after its edge.
  task automatic step(input logic rst, input logic aa, input logic ab,
                      input logic [1:0] la, input logic [1:0] lb,
                      input logic [3:0] eqa, input logic [3:0] eqb,
                      input logic eda, input logic edb,
                      input logic [1:0] eovf, input logic ev,
                      input logic [1:0] ec);
    exp_t e;
    @(negedge clk);
    #1;
    reset = rst;
    arr_a = aa;
    arr_b = ab;
    La    = la;
    Lb    = lb;
    e.id   = 8'(cyc_id);
    e.qa   = eqa;
    e.qb   = eqb;
    e.ta   = (eqa != 4'd0);
    e.tb   = (eqb != 4'd0);
    e.da   = eda;
    e.db   = edb;
    e.ovf  = eovf;
    e.viol = ev;
    e.code = ec;
    sb_q.push_back(e);
    cyc_id++;
  endtask

  // Monitor: compare the DUT against the oldest expectation each cycle.
  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      got.id   = e.id;
      got.qa   = qa;
      got.qb   = qb;
      got.ta   = Ta;
      got.tb   = Tb;
      got.da   = dep_a;
      got.db   = dep_b;
      got.ovf  = ovf;
      got.viol = viol;
      got.code = viol_code;
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL cyc%0d: got qa=%0d qb=%0d Ta=%b Tb=%b dep=%b%b ovf=%b viol=%b code=%b, want qa=%0d qb=%0d Ta=%b Tb=%b dep=%b%b ovf=%b viol=%b code=%b",
                 e.id, got.qa, got.qb, got.ta, got.tb, got.da, got.db,
                 got.ovf, got.viol, got.code, e.qa, e.qb, e.ta, e.tb,
                 e.da, e.db, e.ovf, e.viol, e.code);
      end
    end
  end

  initial begin
    total  = 0;
    bad    = 0;
    cyc_id = 0;
    reset  = 1'b1;
    arr_a  = 1'b0;
    arr_b  = 1'b0;
    La     = R;
    Lb     = R;

    //   rst  aa    ab    La Lb  qa     qb     da    db    ovf    viol  code
    step(1'b1, 1'b0, 1'b0, R, R, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    // Three arrivals on red: queue fills, no departures.
    step(1'b0, 1'b1, 1'b0, R, R, 4'd1, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b0, 1'b1, 1'b0, R, R, 4'd2, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b0, 1'b1, 1'b0, R, R, 4'd3, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    // Green held: one departure every two cycles, then the queue idles.
    step(1'b0, 1'b0, 1'b0, G, R, 4'd3, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, G, R, 4'd2, 4'd0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, G, R, 4'd2, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, G, R, 4'd1, 4'd0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, G, R, 4'd1, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, G, R, 4'd0, 4'd0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, G, R, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, G, R, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    // Arrival on empty green queue, then arrival coinciding with departure.
    step(1'b0, 1'b1, 1'b0, G, R, 4'd1, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, G, R, 4'd1, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b0, 1'b1, 1'b0, G, R, 4'd1, 4'd0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, G, R, 4'd1, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    // Yellow right when the timer would expire: no departure.
    step(1'b0, 1'b0, 1'b0, Y, R, 4'd1, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, R, R, 4'd1, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    // Fill street B to 15.
    for (int i = 1; i <= 15; i++) begin
      step(1'b0, 1'b0, 1'b1, R, R, 4'd1, 4'(i), 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    end
    // Arrival at 15 is dropped and flags ovf[1]; A drains meanwhile.
    step(1'b0, 1'b0, 1'b1, G, R, 4'd1, 4'd15, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, G, R, 4'd0, 4'd15, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, Y, R, 4'd0, 4'd15, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, R, R, 4'd0, 4'd15, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00);
    // B green: arrival with departure at 15 keeps 15, no further overflow.
    step(1'b0, 1'b0, 1'b0, R, G, 4'd0, 4'd15, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b1, R, G, 4'd0, 4'd15, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, R, G, 4'd0, 4'd15, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, R, G, 4'd0, 4'd14, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, R, Y, 4'd0, 4'd14, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, R, R, 4'd0, 4'd14, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00);
    // Green straight to red: illegal transition, later 11 keeps code 10.
    step(1'b0, 1'b0, 1'b0, G, R, 4'd0, 4'd14, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, R, R, 4'd0, 4'd14, 1'b0, 1'b0, 2'b10, VCHK,
         VCHK ? 2'b10 : 2'b00);
    step(1'b0, 1'b0, 1'b0, X, R, 4'd0, 4'd14, 1'b0, 1'b0, 2'b10, VCHK,
         VCHK ? 2'b10 : 2'b00);
    // Reset clears everything, then both non-red outranks B's bad step.
    step(1'b1, 1'b0, 1'b0, R, R, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, G, Y, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, VCHK,
         VCHK ? 2'b01 : 2'b00);
    step(1'b1, 1'b0, 1'b0, R, R, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    // qa=5, timer at 1, then reset mid-green with an arrival: all discarded.
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 1'b0, R, R, 4'(i), 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    end
    step(1'b0, 1'b0, 1'b0, G, R, 4'd5, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b1, 1'b1, 1'b0, G, R, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, G, R, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, G, R, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);

    // Let the monitor drain the last expectation.
    @(negedge clk);
    @(negedge clk);
    #2;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tlc_traffic_model.md
TLC_TRAFFIC_MODEL -- requirements
Module: tlc_traffic_model

Interface
REQ-001 Parameter DEP_CYCLES, default 2, meaning: green-light cycles per car departure, legal range 1..15.
REQ-002 Port clk  input  1  sole clock, all state updates on posedge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port arr_a  input  1  car-arrival pulse, street A, one car per asserted cycle.
REQ-005 Port arr_b  input  1  car-arrival pulse, street B.
REQ-006 Port La  input  2  street A light: green=00, yellow=01, red=10, 11 illegal.
REQ-007 Port Lb  input  2  street B light, same encoding.
REQ-008 Port Ta  output  1  street A traffic sensor, high when A queue nonempty.
REQ-009 Port Tb  output  1  street B traffic sensor.
REQ-010 Port qa  output  4  street A queue count.
REQ-011 Port qb  output  4  street B queue count.
REQ-012 Port dep_a  output  1  one-cycle pulse, car departed street A.
REQ-013 Port dep_b  output  1  one-cycle pulse, car departed street B.
REQ-014 Port ovf  output  2  sticky queue-overflow flags, bit0 = A, bit1 = B.
REQ-015 Port viol  output  1  sticky light-sequence violation flag.
REQ-016 Port viol_code  output  2  code of first violation: 00 illegal encoding, 01 both non-red, 10 illegal transition, 11 unused.

Function
REQ-017 Streets A and B SHALL be identical, independent instances of the queue/departure logic.
REQ-018 Queue count SHALL increment on arrival, decrement on departure, and stay unchanged when both occur in the same cycle.
REQ-019 Arrival at count 15 with no same-cycle departure SHALL be dropped, hold count at 15, and set the street's ovf bit.
REQ-020 Departure timer (4-bit) SHALL count cycles while the light is 00 and the queue is nonzero; it SHALL clear whenever the light is not 00 or the queue is 0.
REQ-021 When the timer reaches DEP_CYCLES-1 with the light at 00 and the queue nonzero, the next edge SHALL decrement the queue, assert dep_x for exactly that following cycle, and clear the timer.
REQ-022 Yellow (01), red (10) and illegal (11) lights SHALL never produce departures.
REQ-023 Ta/Tb SHALL equal (qa!=0)/(qb!=0) from the registered counts, so the sensor follows the queue register with zero added latency.
REQ-024 Monitor SHALL register the previous La and Lb each cycle and check, per street, that only hold, 10->00, 00->01 and 01->10 occur; any other change SHALL raise code 10.
REQ-025 Either light equal to 11 SHALL raise code 00; La!=10 and Lb!=10 in the same cycle SHALL raise code 01.
REQ-026 Multiple violations in one cycle SHALL be prioritised 00 > 01 > 10.
REQ-027 viol SHALL assert one cycle after the offending light value and stay high until reset; viol_code SHALL capture only the first violation.
REQ-028 Departure logic SHALL continue to operate after a violation.

Reset
REQ-029 While reset is high at a posedge: qa=qb=0, both timers=0, dep_a=dep_b=0, ovf=00, viol=0, viol_code=00, and the previous-light registers=10 (red).
REQ-030 Reset SHALL take priority over same-cycle arrivals and violations; reset asserted mid-green SHALL discard any partial departure count.

Configuration
REQ-031 Macro TLC_VIOLATION_CHECK_EN SHALL gate the monitor (REQ-024..REQ-027).
REQ-032 With the macro defined, the monitor SHALL be built as specified above.
REQ-033 Without the macro, the monitor SHALL NOT be built, viol and viol_code SHALL be tied to 0, and ports and queue behaviour SHALL be unchanged.

Verification
REQ-034 Reset, then three arr_a pulses with La=10 -> qa=3 and Ta=1 after the third edge, with no dep_a.
REQ-035 qa=3, La=00 held, DEP_CYCLES=2 -> dep_a pulses every 2 cycles and qa goes 2,1,0; Ta=0 after the last departure and the timer idles.
REQ-036 qb=15, arr_b pulse with La=00 and Lb=10 -> qb stays 15 and ovf=10; a later arrival coinciding with a departure leaves qb unchanged.
REQ-037 La goes 00->10 directly (macro on) -> viol=1, viol_code=10 on the next cycle; a subsequent La=11 leaves viol_code at 10.
REQ-038 La=00 and Lb=01 simultaneously -> viol_code=01 (macro on); the same stimulus with the macro off -> viol=0.
REQ-039 Reset asserted mid-green with qa=5 and the timer at 1 -> qa=0, dep_a never pulses, and viol is cleared.
